// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared types, widths and helpers for the LED frame arbiter
package led_arb_pkg;
  localparam int FRAME_W = 16;
  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_arb_prio_enc.sv
// led_arb_prio_enc: find-first-set over a request mask, bit 0 has highest priority
module led_arb_prio_enc import led_arb_pkg::*; #(
  parameter int N = 3,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  mask,
  output logic          any,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot
);
  // lowest set bit wins; scanning downward lets the lowest index overwrite last
  always_comb begin
    any = |mask;
    onehot = mask & (~mask + N'(1));
    index = '0;
    for (int i = N - 1; i >= 0; i--) index = mask[i] ? IW'(i) : index;
  end
endmodule

// File: rtl/led_frame_arbiter.sv
// led_frame_arbiter: fixed-priority owner arbitration of the LED matrix frame with hold time and lease timeout
module led_frame_arbiter import led_arb_pkg::*; #(
  parameter int N_REQ = 3,
  parameter int HOLD_CYC = 48000,
  parameter int LEASE_CYC = 4800000,
  parameter logic [FRAME_W-1:0] IDLE_FRAME = 16'h0000,
  localparam int IW = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [FRAME_W*N_REQ-1:0] req_frame,
  input  logic [N_REQ-1:0]         req_release,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         grant,
  output logic                     owner_valid,
  output logic [IW-1:0]            owner_id,
  output logic                     preempt,
  output logic [FRAME_W-1:0]       ledbits
);
  localparam int CW = $clog2(LEASE_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LEASE_LAST = CW'(LEASE_CYC - 1);
  state_t state, state_n;
  logic [CW-1:0] hold_cnt, lease_cnt, hold_n, lease_n;
  logic [N_REQ-1:0] grant_n, sel_mask, all_oh, sel_oh;
  logic [IW-1:0] id_n, all_idx, sel_idx;
  logic [FRAME_W-1:0] led_n;
  logic ov_n, pre_n, all_any, sel_any, rel, expire, end_t, take;
  assign rel = |(req_release & grant);
  assign expire = state == OPEN && lease_cnt == LEASE_LAST;
  assign end_t = rel || expire;
  assign sel_mask = req_valid & (end_t ? ~grant : grant - N_REQ'(1));
  assign take = end_t || (state == OPEN && sel_any);
  assign req_ready = state == IDLE ? all_oh : take ? sel_oh : grant;
  led_arb_prio_enc #(.N(N_REQ)) u_enc_all (
    .mask(req_valid), .any(all_any), .index(all_idx), .onehot(all_oh)
  );
  led_arb_prio_enc #(.N(N_REQ)) u_enc_sel (
    .mask(sel_mask), .any(sel_any), .index(sel_idx), .onehot(sel_oh)
  );
  // next owner, frame and tenure counters; a handover or preemption outranks any owner update
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n = owner_id;
    ov_n = owner_valid;
    pre_n = 1'b0;
    led_n = ledbits;
    hold_n = hold_cnt == LEASE_LAST ? hold_cnt : hold_cnt + CW'(1);
    lease_n = lease_cnt == LEASE_LAST ? lease_cnt : lease_cnt + CW'(1);
    if (state == IDLE) begin
      hold_n = '0;
      lease_n = '0;
      if (all_any) begin
        state_n = HOLD;
        grant_n = all_oh;
        id_n = all_idx;
        ov_n = 1'b1;
        led_n = req_frame[all_idx*FRAME_W +: FRAME_W];
      end
    end else if (take && sel_any) begin
      state_n = HOLD;
      grant_n = sel_oh;
      id_n = sel_idx;
      ov_n = 1'b1;
      pre_n = !end_t;
      led_n = req_frame[sel_idx*FRAME_W +: FRAME_W];
      hold_n = '0;
      lease_n = '0;
    end else if (end_t) begin
      state_n = IDLE;
      grant_n = '0;
      id_n = '0;
      ov_n = 1'b0;
      led_n = IDLE_FRAME;
      hold_n = '0;
      lease_n = '0;
    end else begin
      if (|(req_valid & grant)) begin
        led_n = req_frame[owner_id*FRAME_W +: FRAME_W];
        lease_n = '0;
      end
      if (state == HOLD && hold_cnt == HOLD_LAST) state_n = OPEN;
    end
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      owner_id <= '0;
      owner_valid <= 1'b0;
      preempt <= 1'b0;
      ledbits <= IDLE_FRAME;
      hold_cnt <= '0;
      lease_cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner_id <= id_n;
      owner_valid <= ov_n;
      preempt <= pre_n;
      ledbits <= led_n;
      hold_cnt <= hold_n;
      lease_cnt <= lease_n;
    end
  end
endmodule

// File: tb/tb_led_frame_arbiter.sv
// tb_led_frame_arbiter: directed and randomized checks of led_frame_arbiter against a tenure-age reference model
module tb_led_frame_arbiter;
  localparam int HOLD = 4;
  localparam int LEASE = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_release = '0;
  logic [47:0] req_frame = '0;
  logic [2:0] req_ready, grant;
  logic owner_valid, preempt;
  logic [1:0] owner_id;
  logic [15:0] ledbits;
  int n_cmp = 0;
  int n_bad = 0;
  int own = -1;
  int age = 0;
  int idle = 0;
  logic [15:0] m_led = '0;
  logic m_pre = 1'b0;

  always #5 clk = ~clk;

  led_frame_arbiter #(.N_REQ(3), .HOLD_CYC(HOLD), .LEASE_CYC(LEASE), .IDLE_FRAME(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_frame(req_frame),
    .req_release(req_release), .req_ready(req_ready), .grant(grant),
    .owner_valid(owner_valid), .owner_id(owner_id), .preempt(preempt), .ledbits(ledbits)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int first(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1;
    age = 0;
    idle = 0;
    m_led = '0;
    m_pre = 1'b0;
  endtask

  task automatic check_outputs();
    logic [2:0] g;
    g = own < 0 ? 3'b000 : 3'b001 << own;
    chk("ledbits", ledbits, m_led);
    chk("grant", 16'(grant), 16'(g));
    chk("owner_valid", 16'(owner_valid), 16'(own >= 0));
    chk("owner_id", 16'(owner_id), 16'(own < 0 ? 0 : own));
    chk("preempt", 16'(preempt), 16'(m_pre));
  endtask

  task automatic step(input logic [2:0] v, input logic [2:0] r, input logic [47:0] f);
    logic [2:0] rdy;
    int w;
    bit endt, open;
    @(negedge clk);
    req_valid = v;
    req_release = r;
    req_frame = f;
    #1;
    rdy = '0;
    endt = 1'b0;
    if (own < 0) w = first(v);
    else begin
      open = age >= HOLD;
      endt = r[own] || (open && idle >= LEASE - 1);
      if (endt) w = first(v & ~(3'b001 << own));
      else begin
        w = first(v);
        if (!(open && w >= 0 && w < own)) w = own;
      end
    end
    if (w >= 0) rdy[w] = 1'b1;
    chk("ready", 16'(req_ready), 16'(rdy));
    if (w >= 0 && v[w]) begin
      if (w == own) begin
        age++;
        m_pre = 1'b0;
      end else begin
        m_pre = own >= 0 && !endt;
        own = w;
        age = 0;
      end
      m_led = f[w*16 +: 16];
      idle = 0;
    end else if (own >= 0 && endt) begin
      own = -1;
      m_led = '0;
      m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (own >= 0) begin
        age++;
        idle++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int pv, pr;
    logic [2:0] v, r;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("ready_rst", 16'(req_ready), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) step(3'b000, 3'b000, 48'h0);
    step(3'b100, 3'b000, {16'hA5A5, 32'h0});
    chk("own2_led", ledbits, 16'hA5A5);
    chk("own2_grant", 16'(grant), 16'h4);
    step(3'b000, 3'b000, 48'h0);
    step(3'b101, 3'b000, {16'h0F0F, 16'h0, 16'h1234});
    chk("upd_led", ledbits, 16'h0F0F);
    repeat (3) step(3'b001, 3'b000, {32'h0, 16'h1234});
    chk("pre_led", ledbits, 16'h1234);
    chk("pre_pulse", 16'(preempt), 16'h1);
    repeat (6) step(3'b011, 3'b000, {16'h0, 16'hBEEF, 16'h1234});
    step(3'b010, 3'b001, {16'h0, 16'hBEEF, 16'h1234});
    chk("hand_led", ledbits, 16'hBEEF);
    chk("hand_grant", 16'(grant), 16'h2);
    chk("hand_pre", 16'(preempt), 16'h0);
    repeat (16) step(3'b000, 3'b000, 48'h0);
    chk("lease_ov", 16'(owner_valid), 16'h0);
    step(3'b010, 3'b000, {16'h0, 16'h1111, 16'h0});
    repeat (5) step(3'b000, 3'b000, 48'h0);
    step(3'b010, 3'b010, {16'h0, 16'hFFFF, 16'h0});
    chk("rel_wins", ledbits, 16'h0000);
    step(3'b001, 3'b000, {32'h0, 16'hCAFE});
    step(3'b000, 3'b000, 48'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_led", ledbits, 16'h0000);
    chk("arst_grant", 16'(grant), 16'h0);
    chk("arst_ov", 16'(owner_valid), 16'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int s = 0; s < 50; s++) begin
      pv = (s % 4 == 0) ? 10 : (s % 4 == 1) ? 30 : (s % 4 == 2) ? 60 : 90;
      pr = (s % 3 == 0) ? 0 : (s % 3 == 1) ? 5 : 25;
      repeat (40) begin
        for (int i = 0; i < 3; i++) begin
          v[i] = $urandom_range(99) < pv;
          r[i] = $urandom_range(99) < pr;
        end
        step(v, r, {16'($urandom), 32'($urandom)});
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
